// File: rtl/dram_resp_pkg.sv
// Shared types and constants for the DRAM responder: FSM state encoding,
// burst geometry and the beat-ordering helper.
package dram_resp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SEND
    } state_e;

    // One block is eight 64-bit beats.
    localparam int BEATS  = 8;
    localparam int BEAT_W = 3;

    // Word offset inside the block for a given beat. With first = 0 this is
    // linear order; with first = critical word it is wrap order. The 3-bit
    // add wraps modulo 8 by construction.
    function automatic logic [BEAT_W-1:0] beat_offset(
        input logic [BEAT_W-1:0] first,
        input logic [BEAT_W-1:0] beat
    );
        return first + beat;
    endfunction

endpackage : dram_resp_pkg

// File: rtl/dram_responder_if.sv
// Request/response bus between an initiator (master) and the DRAM responder
// (slave). Request channel: reqcyc/reqack with address and tag. Response
// channel: respcyc/respack with beat data and echoed tag.
interface dram_responder_if #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
);

    logic                      bus_reqcyc;
    logic                      bus_reqack;
    logic [BUS_DATA_WIDTH-1:0] bus_req;
    logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
    logic                      bus_respcyc;
    logic                      bus_respack;
    logic [BUS_DATA_WIDTH-1:0] bus_resp;
    logic [BUS_TAG_WIDTH-1:0]  bus_resptag;

    modport master (
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );

    modport slave (
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        output bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );

endinterface : dram_responder_if

// File: rtl/dram_resp_store.sv
// Backing store for the DRAM responder: MEM_WORDS x 64-bit words, each word
// initialised to its own index on reset, with one combinational read port.
module dram_resp_store #(
    parameter  int MEM_WORDS = 256,
    localparam int IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [63:0]      rd_data
);

    logic [63:0] mem_q [MEM_WORDS];
    logic [63:0] mem_d [MEM_WORDS];

    // Contents are read-only between resets; the next value is the current one.
    always_comb begin
        mem_d = mem_q;
    end

    // Load the index pattern on reset, otherwise hold.
    // NOTE: the array is reset on purpose because its contents are defined
    // by reset; a plain RAM macro without reset could not hold this pattern.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem_q[i] <= 64'(i);
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule : dram_resp_store

// File: rtl/dram_responder.sv
// DRAM responder: accepts one block-read request at a time, waits LATENCY
// cycles, then returns eight 64-bit beats from the backing store with the
// request tag echoed on every beat.
// Optional feature: define DRAM_RESP_WRAP_EN for critical-word-first beat
// order; otherwise beats are returned in linear order from the block base.
module dram_responder
    import dram_resp_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_WORDS      = 256,
    parameter int LATENCY        = 4
) (
    input logic              clk,
    input logic              reset,
    dram_responder_if.slave  bus_if
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [BEAT_W-1:0]        beat_q, beat_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [BUS_TAG_WIDTH-1:0] tag_q, tag_d;
    logic                     reqack_q, reqack_d;

    logic [BEAT_W-1:0]        first_off;
    logic [IDX_W-1:0]         rd_idx;
    logic [63:0]              rd_data;

    // Next-state and datapath updates for the request/wait/send sequence.
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        beat_d   = beat_q;
        idx_d    = idx_q;
        tag_d    = tag_q;
        reqack_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (reqack_q) begin
                    // Handshake edge: reqack is high this cycle. Only the word
                    // index is kept; address bits outside it are ignored.
                    if (bus_if.bus_reqcyc) begin
                        idx_d = bus_if.bus_req[3 +: IDX_W];
                        tag_d = bus_if.bus_reqtag;
                        if (LATENCY == 0) begin
                            state_d = SEND;
                        end else begin
                            state_d = WAIT;
                            cnt_d   = CNT_W'(LATENCY);
                        end
                    end
                end else if (bus_if.bus_reqcyc) begin
                    reqack_d = 1'b1;
                end
            end

            WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = SEND;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            SEND: begin
                // respcyc is high throughout SEND, so respack alone marks a
                // consumed beat; respack outside SEND is never looked at.
                if (bus_if.bus_respack) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            beat_q   <= '0;
            idx_q    <= '0;
            tag_q    <= '0;
            reqack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            beat_q   <= beat_d;
            idx_q    <= idx_d;
            tag_q    <= tag_d;
            reqack_q <= reqack_d;
        end
    end

`ifdef DRAM_RESP_WRAP_EN
    assign first_off = idx_q[BEAT_W-1:0];
`else
    assign first_off = '0;
`endif

    assign rd_idx = {idx_q[IDX_W-1:BEAT_W], beat_offset(first_off, beat_q)};

    dram_resp_store #(
        .MEM_WORDS (MEM_WORDS)
    ) u_store (
        .clk     (clk),
        .reset   (reset),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    assign bus_if.bus_reqack  = reqack_q;
    assign bus_if.bus_respcyc = (state_q == SEND);
    assign bus_if.bus_resp    = (state_q == SEND) ? BUS_DATA_WIDTH'(rd_data) : '0;
    assign bus_if.bus_resptag = tag_q;

endmodule : dram_responder
